// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared types and constants for the two-port SRAM arbiter:
//               FSM state encoding, full byte-enable mask and port indices.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic [3:0] B_EN_ALL = 4'hF;

    // Port indices, also used as the last-granted pointer encoding
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pick
// Description : Two-way combinational tie-break between the fetch port and
//               the data port. Requests arriving here are already qualified
//               (arbiter idle, out of reset), so grants may be passed straight
//               to the ports.
//               Build option SRAM_ARB_RR_EN: ties go to the port that was not
//               granted last (i_last). Without it the data port always wins.
// Ports       : i_last  - last-granted port (SRAM_ARB_RR_EN builds only)
//               i_req_i - qualified fetch request
//               i_req_d - qualified data request
//               o_gnt_i - fetch grant
//               o_gnt_d - data grant
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_pick (
`ifdef SRAM_ARB_RR_EN
    input  logic i_last,
`endif
    input  logic i_req_i,
    input  logic i_req_d,
    output logic o_gnt_i,
    output logic o_gnt_d
);

    always_comb begin
        o_gnt_i = 1'b0;
        o_gnt_d = 1'b0;
`ifdef SRAM_ARB_RR_EN
        if (i_req_i && i_req_d) begin
            o_gnt_d = (i_last == sram_arb_pkg::PORT_I);
            o_gnt_i = (i_last == sram_arb_pkg::PORT_D);
        end else begin
            o_gnt_i = i_req_i;
            o_gnt_d = i_req_d;
        end
`else
        o_gnt_d = i_req_d;
        o_gnt_i = i_req_i & ~i_req_d;
`endif
    end

endmodule : sram_arb_pick
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Arbitrates an instruction-fetch port and a data port onto a
//               single SRAM with one transaction outstanding. Reads take
//               RD_LAT+1 cycles from grant to rvalid, writes take 2. A data
//               request with all byte enables low completes with an error
//               without touching the SRAM.
//               Build option SRAM_ARB_RR_EN: round-robin tie-break instead of
//               fixed data-port priority.
// Ports       : gclk, resetn            - clock, async active-low reset
//               i_req/i_addr/i_gnt/i_rvalid          - fetch port
//               d_req/d_addr/d_wdata/d_b_en/d_w_en/
//               d_gnt/d_rvalid                       - data port
//               r_data/r_error          - shared response
//               m_addr/m_wdata/m_b_en/m_w_en         - SRAM request bus
//               m_rdata/m_stall/m_error - SRAM response
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              gclk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_b_en,
    input  logic              d_w_en,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] r_data,
    output logic              r_error,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_b_en,
    output logic              m_w_en,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_stall,
    input  logic              m_error
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_port;     // port owning the outstanding transaction
    logic             r_write;
    logic             r_berr;     // zero byte-enable request, no SRAM access
    logic             r_err_acc;  // m_error accumulated over ISSUE/WAIT
    logic             w_arb_en;
    logic             w_gnt_i;
    logic             w_gnt_d;
    logic             w_berr;

    // Reset is folded in so both grants read 0 while resetn is low
    assign w_arb_en = resetn && (r_state == ST_IDLE);
    assign w_berr   = w_gnt_d && (d_b_en == 4'h0);

`ifdef SRAM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge gclk or negedge resetn) begin
        if (!resetn) begin
            r_last <= PORT_I;
        end else if (w_gnt_i) begin
            r_last <= PORT_I;
        end else if (w_gnt_d) begin
            r_last <= PORT_D;
        end
    end
`endif

    sram_arb_pick u_pick (
`ifdef SRAM_ARB_RR_EN
        .i_last  (r_last),
`endif
        .i_req_i (w_arb_en & i_req),
        .i_req_d (w_arb_en & d_req),
        .o_gnt_i (w_gnt_i),
        .o_gnt_d (w_gnt_d)
    );

    assign i_gnt = w_gnt_i;
    assign d_gnt = w_gnt_d;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge gclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        r_data   = '0;
        r_error  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_berr) begin
                    w_next = ST_RESP;
                end else if (w_gnt_i || w_gnt_d) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!m_stall) begin
                    w_next = (r_write || (RD_LAT == 1)) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!m_stall && (r_cnt == CNT_W'(1))) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next   = ST_IDLE;
                i_rvalid = (r_port == PORT_I);
                d_rvalid = (r_port == PORT_D);
                r_error  = r_err_acc | m_error;
                if (!r_write && !r_berr) begin
                    r_data = m_rdata;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Request bus, wait counter and transaction attributes
    // ------------------------------------------------------------------------
    always_ff @(posedge gclk or negedge resetn) begin
        if (!resetn) begin
            m_addr    <= '0;
            m_wdata   <= '0;
            m_b_en    <= 4'h0;
            m_w_en    <= 1'b0;
            r_cnt     <= '0;
            r_port    <= PORT_I;
            r_write   <= 1'b0;
            r_berr    <= 1'b0;
            r_err_acc <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_i) begin
                        m_addr    <= i_addr;
                        m_wdata   <= '0;
                        m_b_en    <= B_EN_ALL;
                        m_w_en    <= 1'b0;
                        r_port    <= PORT_I;
                        r_write   <= 1'b0;
                        r_berr    <= 1'b0;
                        r_err_acc <= 1'b0;
                    end else if (w_gnt_d) begin
                        r_port  <= PORT_D;
                        r_write <= d_w_en;
                        if (w_berr) begin
                            // Bus left idle: the request is answered locally
                            r_berr    <= 1'b1;
                            r_err_acc <= 1'b1;
                        end else begin
                            m_addr    <= d_addr;
                            m_wdata   <= d_wdata;
                            m_b_en    <= d_b_en;
                            m_w_en    <= d_w_en;
                            r_berr    <= 1'b0;
                            r_err_acc <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_err_acc <= r_err_acc | m_error;
                    if (!m_stall) begin
                        m_w_en <= 1'b0;
                        if (w_next == ST_RESP) begin
                            m_b_en <= 4'h0;
                        end else begin
                            r_cnt <= CNT_W'(RD_LAT - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    r_err_acc <= r_err_acc | m_error;
                    if (!m_stall) begin
                        if (r_cnt == CNT_W'(1)) begin
                            m_b_en <= 4'h0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Directed self-checking bench for sram_arbiter (RD_LAT=2) with
//               a small behavioural SRAM: 64 words, addresses >= 0x100 raise
//               m_error, read data registered each cycle the bus is active.
//               Tie-break expectations follow SRAM_ARB_RR_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic        gclk;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_b_en;
    logic        d_w_en;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] r_data;
    logic        r_error;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_b_en;
    logic        m_w_en;
    logic [31:0] m_rdata;
    logic        m_stall;
    logic        m_error;

    int vectors;
    int miscompares;

    sram_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .RD_LAT (2)
    ) dut (
        .gclk     (gclk),
        .resetn   (resetn),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_b_en   (d_b_en),
        .d_w_en   (d_w_en),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .r_data   (r_data),
        .r_error  (r_error),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_b_en   (m_b_en),
        .m_w_en   (m_w_en),
        .m_rdata  (m_rdata),
        .m_stall  (m_stall),
        .m_error  (m_error)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // ---------------- behavioural SRAM ----------------
    logic [31:0] mem [0:63];
    logic [31:0] rd_q;
    logic        mem_init;

    assign m_error = (m_b_en != 4'h0) && (m_addr >= 32'h100);
    assign m_rdata = rd_q;

    always @(posedge gclk) begin
        if (mem_init) begin
            mem[4] <= 32'hDEADBEEF;
            mem[8] <= 32'h11223344;
            rd_q   <= 32'h0;
        end else if ((m_b_en != 4'h0) && !m_stall) begin
            if (m_addr >= 32'h100) begin
                rd_q <= 32'h0;
            end else if (m_w_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_b_en[b]) mem[m_addr[7:2]][8*b +: 8] <= m_wdata[8*b +: 8];
                end
            end else begin
                rd_q <= mem[m_addr[7:2]];
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fetch with no stall: grant now, rvalid three cycles later
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
        i_req  = 1'b1;
        i_addr = addr;
        #1;
        check({tag, "_gnt"}, i_gnt, 1);
        tick();
        i_req = 1'b0;
        tick();
        #1;
        check({tag, "_early"}, i_rvalid, 0);
        tick();
        #1;
        check({tag, "_rvalid"}, i_rvalid, 1);
        check({tag, "_err"}, r_error, exp_err);
        if (!exp_err) check({tag, "_data"}, r_data, exp_data);
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetn   = 1'b0;
        mem_init = 1'b1;
        i_req    = 1'b1;
        d_req    = 1'b1;
        i_addr   = 32'h0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        d_b_en   = 4'hF;
        d_w_en   = 1'b0;
        m_stall  = 1'b0;

        // ---- reset state: requests present but nothing granted ----
        tick();
        tick();
        check("rst_i_gnt", i_gnt, 0);
        check("rst_d_gnt", d_gnt, 0);
        check("rst_m_b_en", m_b_en, 0);
        check("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        i_req    = 1'b0;
        d_req    = 1'b0;
        mem_init = 1'b0;
        resetn   = 1'b1;
        tick();

        // ---- fetch 0x10 -> DEADBEEF, rvalid at cycle 3 ----
        i_req  = 1'b1;
        i_addr = 32'h10;
        #1;
        check("f1_gnt", {i_gnt, d_gnt}, 2'b10);
        tick();
        i_req = 1'b0;
        #1;
        check("f1_m_addr", m_addr, 32'h10);
        check("f1_m_b_en", m_b_en, 4'hF);
        check("f1_m_w_en", m_w_en, 0);
        tick();
        #1;
        check("f1_c2_rvalid", i_rvalid, 0);
        tick();
        #1;
        check("f1_c3_rvalid", {i_rvalid, d_rvalid}, 2'b10);
        check("f1_data", r_data, 32'hDEADBEEF);
        check("f1_resp_b_en", m_b_en, 0);
        tick();
        #1;
        check("f1_c4_idle", {i_rvalid, r_data}, 0);

        // ---- data write 0xAB to 0x20, byte 0 ----
        d_req   = 1'b1;
        d_addr  = 32'h20;
        d_wdata = 32'h000000AB;
        d_b_en  = 4'b0001;
        d_w_en  = 1'b1;
        #1;
        check("w_gnt", {i_gnt, d_gnt}, 2'b01);
        tick();
        d_req = 1'b0;
        #1;
        check("w_m_bus", {m_w_en, m_b_en, m_wdata}, {1'b1, 4'b0001, 32'h000000AB});
        tick();
        #1;
        check("w_rvalid", {d_rvalid, i_rvalid}, 2'b10);
        check("w_resp", {m_w_en, m_b_en, r_data, r_error}, 0);
        tick();
        fetch("f2", 32'h20, 32'h112233AB, 1'b0);

        // ---- both ports requesting continuously ----
        i_req  = 1'b1;
        i_addr = 32'h10;
        d_req  = 1'b1;
        d_addr = 32'h10;
        d_b_en = 4'hF;
        d_w_en = 1'b0;
        for (int g = 0; g < 3; g++) begin
            #1;
`ifdef SRAM_ARB_RR_EN
            check("tie_gnt", {i_gnt, d_gnt}, (g == 1) ? 2'b10 : 2'b01);
`else
            check("tie_gnt", {i_gnt, d_gnt}, 2'b01);
`endif
            if (g == 2) begin
                tick();
                i_req = 1'b0;
                d_req = 1'b0;
                tick();
                tick();
                #1;
                check("tie_last_rvalid", {i_rvalid, d_rvalid}, 2'b01);
                tick();
            end else begin
                tick();
                tick();
                tick();
                #1;
                check("tie_rvalid_data", r_data, 32'hDEADBEEF);
                tick();
            end
        end

        // ---- stall three cycles in WAIT ----
        i_req  = 1'b1;
        i_addr = 32'h10;
        #1;
        check("st_gnt", i_gnt, 1);
        tick();
        i_req = 1'b0;
        tick();
        m_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("st_hold", {i_rvalid, m_b_en, m_w_en, m_addr}, {1'b0, 4'hF, 1'b0, 32'h10});
            tick();
        end
        m_stall = 1'b0;
        #1;
        check("st_c5_rvalid", i_rvalid, 0);
        tick();
        #1;
        check("st_c6_rvalid", {i_rvalid, r_data}, {1'b1, 32'hDEADBEEF});
        tick();

        // ---- zero byte enables: immediate error response, no bus activity ----
        d_req  = 1'b1;
        d_addr = 32'h10;
        d_b_en = 4'h0;
        d_w_en = 1'b0;
        #1;
        check("be0_gnt", d_gnt, 1);
        tick();
        d_req = 1'b0;
        #1;
        check("be0_resp", {d_rvalid, r_error, m_b_en, r_data}, {1'b1, 1'b1, 4'h0, 32'h0});
        tick();
        #1;
        check("be0_after", {d_rvalid, r_error, m_b_en}, 0);

        // ---- out-of-range fetch returns error ----
        fetch("oor", 32'h400, 32'h0, 1'b1);

        // ---- reset during WAIT of a data read ----
        d_req  = 1'b1;
        d_addr = 32'h10;
        d_b_en = 4'hF;
        #1;
        check("rw_gnt", d_gnt, 1);
        tick();
        d_req = 1'b0;
        tick();
        resetn = 1'b0;
        i_req  = 1'b1;
        #1;
        check("rw_outputs", {i_gnt, d_gnt, i_rvalid, d_rvalid, m_b_en, m_w_en, m_addr, r_data, r_error}, 0);
        tick();
        i_req  = 1'b0;
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rw_no_rvalid", {i_rvalid, d_rvalid}, 0);
            tick();
        end
        // first tie after reset goes to the data port in both builds
        i_req = 1'b1;
        d_req = 1'b1;
        #1;
        check("rw_tie_gnt", {i_gnt, d_gnt}, 2'b01);
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        #1;
        check("rw_d_rvalid", {d_rvalid, r_data}, {1'b1, 32'hDEADBEEF});
        tick();
        fetch("rw_f", 32'h20, 32'h112233AB, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sram_arbiter
`default_nettype wire
